// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types and defaults for the CPU memory port arbiter
package cpu_mem_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;
endpackage

// File: rtl/arb_priority_pick.sv
// arb_priority_pick: data-over-fetch grant selection with fetch starvation override
module arb_priority_pick (
  input  logic if_req,
  input  logic d_req,
  input  logic starve,
  output logic gnt_if,
  output logic gnt_d
);
  // data wins unless fetch has been passed over MAX_STREAK times in a row
  always_comb begin
    gnt_d = d_req && !(if_req && starve);
    gnt_if = if_req && !gnt_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store with timeout
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ready,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                owner
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);
  localparam logic [SW-1:0] MS = SW'(MAX_STREAK);
  state_t state, nxt;
  owner_t owner_q;
  logic [CW-1:0] cnt;
  logic [SW-1:0] streak;
  logic gnt_if, gnt_d, hs, tmo, resp, idle;
  logic [DATA_W-1:0] rdata;
  arb_priority_pick u_pick (
    .if_req(if_req),
    .d_req (d_req),
    .starve(streak == MS),
    .gnt_if(gnt_if),
    .gnt_d (gnt_d)
  );
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  // next state, grants and pass-through responses; a handshake beats a same-cycle timeout
  always_comb begin
    hs = (state == ISSUE && mem_gnt) || (state == WAIT && mem_rvalid);
    tmo = state != IDLE && !hs && cnt == TO;
    resp = !reset && ((state == WAIT && mem_rvalid) || tmo);
    idle = !reset && state == IDLE;
    nxt = state == IDLE ? ((gnt_if || gnt_d) ? ISSUE : IDLE) :
          tmo ? IDLE :
          (state == ISSUE && mem_gnt) ? WAIT :
          (state == WAIT && mem_rvalid) ? IDLE : state;
    rdata = (tmo || mem_we) ? '0 : mem_rdata;
    if_ready = idle && gnt_if;
    d_ready = idle && gnt_d;
    if_rvalid = resp && owner_q == OWN_IF;
    d_rvalid = resp && owner_q == OWN_D;
    if_rdata = if_rvalid ? rdata : '0;
    d_rdata = d_rvalid ? rdata : '0;
    if_err = if_rvalid && tmo;
    d_err = d_rvalid && tmo;
    busy = state != IDLE;
    owner = owner_q;
  end
  // request latch, saturating timeout counter and fetch-starvation streak
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_be <= '0;
      owner_q <= OWN_IF;
      cnt <= '0;
      streak <= '0;
    end else begin
      if (if_ready || d_ready) begin
        mem_req <= 1'b1;
        mem_we <= d_ready && d_we;
        mem_addr <= d_ready ? d_addr : if_addr;
        mem_wdata <= d_ready ? d_wdata : '0;
        mem_be <= d_ready ? d_be : '1;
        owner_q <= d_ready ? OWN_D : OWN_IF;
        cnt <= '0;
      end else if (state != IDLE) begin
        cnt <= cnt == TO ? cnt : cnt + CW'(1);
      end
      if ((state == ISSUE && mem_gnt) || tmo) mem_req <= 1'b0;
      if (state == IDLE) streak <= (!if_req || gnt_if) ? '0 : (gnt_d && streak != MS) ? streak + SW'(1) : streak;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 0, reset = 1;
  logic if_req = 0, d_req = 0, d_we = 0, mem_gnt = 0, mem_rvalid = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [3:0] d_be = 0;
  logic if_ready, if_rvalid, if_err, d_ready, d_rvalid, d_err;
  logic mem_req, mem_we, busy, owner;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  int tests = 0, fails = 0;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 1;
    cyc();
    cyc();
    tests++;
    if ({busy, owner, mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ready, d_ready, if_rvalid, d_rvalid} !== '0) begin
      fails++;
      $display("FAIL reset: busy=%b owner=%b mem_req=%b mem_addr=%h got nonzero outputs, want all 0", busy, owner, mem_req, mem_addr);
    end
    @(negedge clk);
    reset = 0;
    #1;
  endtask
  task automatic test_single_load();
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 32'h100;
    #1;
    tests++;
    if (d_ready !== 1 || if_ready !== 0) begin fails++; $display("FAIL load_ready: d_ready=%b if_ready=%b want 1/0", d_ready, if_ready); end
    @(negedge clk);
    d_req = 0; mem_gnt = 1;
    #1;
    tests++;
    if (mem_req !== 1 || mem_addr !== 32'h100 || mem_we !== 0) begin fails++; $display("FAIL load_issue: mem_req=%b mem_addr=%h mem_we=%b want 1/100/0", mem_req, mem_addr, mem_we); end
    @(negedge clk);
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    tests++;
    if (d_rvalid !== 1 || d_rdata !== 32'hDEADBEEF || d_err !== 0 || if_rvalid !== 0) begin fails++; $display("FAIL load_resp: d_rvalid=%b d_rdata=%h d_err=%b want 1/deadbeef/0", d_rvalid, d_rdata, d_err); end
    @(negedge clk);
    mem_rvalid = 0;
    #1;
    tests++;
    if (busy !== 0 || owner !== 1 || mem_req !== 0) begin fails++; $display("FAIL load_idle: busy=%b owner=%b mem_req=%b want 0/1/0", busy, owner, mem_req); end
  endtask
  task automatic test_store_ack();
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 32'h204; d_wdata = 32'h12345678; d_be = 4'hF;
    #1;
    tests++;
    if (d_ready !== 1) begin fails++; $display("FAIL store_ready: d_ready=%b want 1", d_ready); end
    @(negedge clk);
    d_req = 0; d_we = 0; mem_gnt = 1;
    #1;
    tests++;
    if (mem_req !== 1 || mem_we !== 1 || mem_wdata !== 32'h12345678 || mem_be !== 4'hF || mem_addr !== 32'h204) begin
      fails++; $display("FAIL store_issue: we=%b wdata=%h be=%h addr=%h want 1/12345678/f/204", mem_we, mem_wdata, mem_be, mem_addr);
    end
    @(negedge clk);
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hAAAA5555;
    #1;
    tests++;
    if (d_rvalid !== 1 || d_rdata !== 0 || d_err !== 0) begin fails++; $display("FAIL store_resp: d_rvalid=%b d_rdata=%h d_err=%b want 1/0/0", d_rvalid, d_rdata, d_err); end
    @(negedge clk);
    mem_rvalid = 0;
  endtask
  task automatic test_simultaneous();
    logic [9:0] want = 10'b0111101111;
    int n = 0;
    int both = 0;
    @(negedge clk);
    if_req = 1; if_addr = 32'h4000; d_req = 1; d_we = 0; d_addr = 32'h300;
    for (int c = 0; c < 60 && n < 10; c++) begin
      if (c > 0) @(negedge clk);
      mem_gnt = mem_req;
      mem_rvalid = busy && !mem_req;
      mem_rdata = 32'h11110000 + c;
      #1;
      if (if_ready && d_ready) both++;
      if (if_ready || d_ready) begin
        tests++;
        if (d_ready !== want[n]) begin fails++; $display("FAIL grant_order[%0d]: d_ready=%b want %b", n, d_ready, want[n]); end
        n++;
      end
    end
    tests++;
    if (n != 10) begin fails++; $display("FAIL grant_count: %0d grants, want 10", n); end
    tests++;
    if (both != 0) begin fails++; $display("FAIL ready_exclusive: %0d cycles both ready, want 0", both); end
    if_req = 0; d_req = 0;
    for (int c = 0; c < 10 && busy; c++) begin
      @(negedge clk);
      mem_gnt = mem_req;
      mem_rvalid = busy && !mem_req;
      #1;
    end
    @(negedge clk);
    mem_gnt = 0; mem_rvalid = 0;
    #1;
    tests++;
    if (busy !== 0) begin fails++; $display("FAIL sim_drain: busy=%b want 0", busy); end
  endtask
  task automatic test_timeout();
    @(negedge clk);
    if_req = 1; if_addr = 32'h800;
    #1;
    tests++;
    if (if_ready !== 1) begin fails++; $display("FAIL to_ready: if_ready=%b want 1", if_ready); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if_req = 0;
      #1;
      if (k == 8) begin
        tests++;
        if (if_rvalid !== 0 || mem_req !== 1) begin fails++; $display("FAIL to_early: if_rvalid=%b mem_req=%b at cnt 7, want 0/1", if_rvalid, mem_req); end
      end
    end
    @(negedge clk);
    #1;
    tests++;
    if (if_rvalid !== 1 || if_err !== 1 || if_rdata !== 0 || d_rvalid !== 0) begin fails++; $display("FAIL to_resp: if_rvalid=%b if_err=%b if_rdata=%h want 1/1/0", if_rvalid, if_err, if_rdata); end
    @(negedge clk);
    #1;
    tests++;
    if (busy !== 0 || mem_req !== 0) begin fails++; $display("FAIL to_idle: busy=%b mem_req=%b want 0/0", busy, mem_req); end
    mem_rvalid = 1; mem_rdata = 32'h55;
    #1;
    tests++;
    if (if_rvalid !== 0 || d_rvalid !== 0) begin fails++; $display("FAIL to_stray: if_rvalid=%b d_rvalid=%b want 0/0", if_rvalid, d_rvalid); end
    @(negedge clk);
    mem_rvalid = 0;
  endtask
  task automatic test_gnt_tie();
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 32'h900;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      d_req = 0;
    end
    @(negedge clk);
    mem_gnt = 1;
    #1;
    tests++;
    if (d_rvalid !== 0 || d_err !== 0) begin fails++; $display("FAIL tie_gnt: d_rvalid=%b d_err=%b want 0/0", d_rvalid, d_err); end
    @(negedge clk);
    mem_gnt = 0;
    #1;
    tests++;
    if (busy !== 1 || mem_req !== 0) begin fails++; $display("FAIL tie_wait: busy=%b mem_req=%b want 1/0", busy, mem_req); end
    mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    #1;
    tests++;
    if (d_rvalid !== 1 || d_err !== 0 || d_rdata !== 32'hCAFEF00D) begin fails++; $display("FAIL tie_resp: d_rvalid=%b d_err=%b d_rdata=%h want 1/0/cafef00d", d_rvalid, d_err, d_rdata); end
    @(negedge clk);
    mem_rvalid = 0;
  endtask
  task automatic test_mid_reset();
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 32'hA00; d_wdata = 32'h77; d_be = 4'h3;
    @(negedge clk);
    d_req = 0; d_we = 0; mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0; reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    tests++;
    if ({busy, owner, mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== '0) begin fails++; $display("FAIL rst_mid: busy=%b owner=%b mem_req=%b mem_addr=%h want all 0", busy, owner, mem_req, mem_addr); end
    mem_rvalid = 1; mem_rdata = 32'h99;
    #1;
    tests++;
    if (d_rvalid !== 0 || if_rvalid !== 0) begin fails++; $display("FAIL rst_stray: d_rvalid=%b if_rvalid=%b want 0/0", d_rvalid, if_rvalid); end
    @(negedge clk);
    mem_rvalid = 0;
  endtask
  initial begin
    test_reset();
    test_single_load();
    test_store_ack();
    test_simultaneous();
    test_timeout();
    test_gnt_tie();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single memory port between instruction fetch and the load/store unit driven by the decoder's `mem_load`/`mem_store` controls. One transaction is outstanding at a time, with fixed data-over-fetch priority and a starvation guard for fetch. A bus timeout returns an error response instead of hanging the core.

## Interface

Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; byte enables are `DATA_W/8`.
- `MAX_STREAK`, default 4: consecutive data grants allowed while fetch waits.
- `TIMEOUT`, default 255: cycles in ISSUE+WAIT before an error response.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `if_req` in 1: fetch request; held with `if_addr` stable until `if_ready`.
- `if_addr` in ADDR_W: fetch address.
- `if_ready` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1: fetch response pulse.
- `if_rdata` out DATA_W: fetch data, valid with `if_rvalid`.
- `if_err` out 1: fetch timed out, valid with `if_rvalid`.
- `d_req` in 1: data request; held with all `d_*` fields stable until `d_ready`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_be` in DATA_W/8: store byte enables.
- `d_ready` out 1: data request accepted this cycle.
- `d_rvalid` out 1: data response pulse; also the store completion ack.
- `d_rdata` out DATA_W: load data; 0 for stores and errors.
- `d_err` out 1: data timed out, valid with `d_rvalid`.
- `mem_req` out 1: memory request; held until `mem_gnt`.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_be` out DATA_W/8: memory byte enables.
- `mem_gnt` in 1: memory accepted the request.
- `mem_rvalid` in 1: memory response; earliest one cycle after `mem_gnt`.
- `mem_rdata` in DATA_W: memory read data.
- `busy` out 1: state is not IDLE.
- `owner` out 1: 0 = fetch, 1 = data; the current/last granted requester.

## Operation

- FSM states: IDLE, ISSUE, WAIT.
- **IDLE arbitration:**
  - If only one request is pending, grant it.
  - If both are pending, grant data, unless `streak == MAX_STREAK`, in which case grant fetch.
- **Grant in IDLE:** `x_ready` is combinational and high for exactly that cycle. The request fields are latched into `mem_*` registers, `owner` is set, the timeout counter is cleared, and the FSM moves to ISSUE.
- **Streak counter:**
  - Data grant while `if_req` is high: increment, saturating at MAX_STREAK.
  - Fetch grant, or any cycle in IDLE with `if_req` low: clear to 0.
- **ISSUE:** `mem_req` = 1. On `mem_gnt`, drop `mem_req` and move to WAIT.
- **WAIT:** on `mem_rvalid`, the response is combinational pass-through.
  - The owner's `x_rvalid` = 1.
  - `x_rdata` = `mem_rdata` for a load/fetch, 0 for a store.
  - `x_err` = 0.
  - Move to IDLE.
- **Timeout:** the counter increments every cycle in ISSUE/WAIT. When it equals TIMEOUT and no `mem_gnt`/`mem_rvalid` is present that cycle:
  - the owner gets `x_rvalid` = 1, `x_err` = 1, `x_rdata` = 0;
  - `mem_req` drops and the FSM moves to IDLE.
  - A handshake event arriving in the same cycle takes precedence over the timeout.
- **Ignored inputs:**
  - `mem_rvalid` in IDLE or ISSUE (e.g. a late response after a timeout or reset) is ignored.
  - `mem_gnt` outside ISSUE is ignored.
- **Reset:**
  - All outputs 0, state IDLE, `streak` 0, counter 0, `owner` 0.
  - Reset mid-transaction abandons it with no response to either requester.

## Timing

- Minimum request-to-response latency: grant in cycle 0 → `mem_req` cycle 1 → `mem_gnt` cycle 1 → `mem_rvalid` cycle 2 → `x_rvalid` cycle 2.
- The response cycle is in WAIT; IDLE is reached at cycle 3, so the next grant is no earlier than cycle 3. This gives a sustained throughput of one transaction per 3 cycles.
- `mem_*` outputs are registered.
- `x_ready`, `x_rvalid`, `x_rdata`, `x_err` are combinational from state, arbitration and memory inputs.
- At most one of `if_ready`/`d_ready` is high per cycle; the same holds for `if_rvalid`/`d_rvalid`.

## Structure

- Shared package `cpu_mem_pkg`:
  - state enum (IDLE/ISSUE/WAIT);
  - owner encoding (OWN_IF = 0, OWN_D = 1);
  - ADDR_W/DATA_W defaults.
- Sub-module `arb_priority_pick`: combinational grant selection from `if_req`, `d_req`, `streak == MAX_STREAK`.
- The top level holds the FSM, latches, streak and timeout counters.

## Test plan

- **Single load:** `d_req` = 1, `d_we` = 0, `d_addr` = 0x100. Memory grants in ISSUE cycle 1 and returns 0xDEADBEEF in cycle 2. Required: `d_ready` cycle 0, `mem_addr` = 0x100, `d_rvalid` = 1 with `d_rdata` = 0xDEADBEEF in cycle 2, `d_err` = 0.
- **Store ack:** `d_we` = 1, `d_wdata` = 0x12345678, `d_be` = 0xF. Required: `mem_we` = 1, `mem_wdata`/`mem_be` match, then `d_rvalid` = 1 with `d_rdata` = 0.
- **Simultaneous requests:** `if_req` and `d_req` held high continuously, MAX_STREAK = 4. Grants must follow D,D,D,D,IF,D,D,D,D,IF; `if_ready` and `d_ready` never high together.
- **Timeout:** `mem_gnt` held low, TIMEOUT = 8. Required: the owner gets `x_rvalid` = 1, `x_err` = 1 at counter 8, then `busy` = 0. A stray `mem_rvalid` after that produces no response.
- **Gnt vs timeout tie:** `mem_gnt` arrives exactly at counter == TIMEOUT. Required: no error; the FSM enters WAIT.
- **Mid-transaction reset:** assert `reset` in WAIT. Next cycle: all outputs 0, `busy` = 0; a later `mem_rvalid` produces no `x_rvalid`.
